// File: rtl/alu_op_sequencer.sv
// Byte-ALU command sequencer: captures a short program through a ready/valid
// load port, then replays it onto the ALU inputs one entry per clock.
module alu_op_sequencer #(
    parameter int         DEPTH      = 8,
    parameter logic [3:0] NOP_OPCODE = 4'h0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [5:0]               load_instr,
    input  logic [7:0]               load_data,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     loop_en,
    input  logic                     stop,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     alu_accum_source,
    output logic                     alu_value_source,
    output logic [3:0]               alu_opcode,
    output logic [7:0]               alu_data,
    output logic                     alu_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   count_next;
    logic [PW-1:0]   ptr, ptr_next;
    logic [CW-1:0]   ptr_inc;
    logic [CW-1:0]   eff_count;
    logic            load_fire;
    logic [5:0]      first_instr;
    logic [7:0]      first_data;
    logic            busy_next, done_next, valid_next;
    logic [5:0]      instr_next;
    logic [7:0]      data_next;

    logic [5:0]      instr_mem [DEPTH];
    logic [7:0]      data_mem  [DEPTH];

    assign load_ready = (state == IDLE) && (count < CW'(DEPTH)) && !clear;
    assign load_fire  = load_valid && load_ready;
    assign eff_count  = count + CW'(load_fire);
    assign ptr_inc    = CW'(ptr) + CW'(1);

    // A load and start in the same cycle must replay the entry being written.
    assign first_instr = (count == '0) ? load_instr : instr_mem[0];
    assign first_data  = (count == '0) ? load_data  : data_mem[0];

    always_ff @(posedge clk) begin
        if (load_fire) begin
            instr_mem[count[PW-1:0]] <= load_instr;
            data_mem[count[PW-1:0]]  <= load_data;
        end
    end

    // ptr holds the index of the next entry; ptr==0 in RUN means the last entry is showing.
    always_comb begin
        state_next = state;
        count_next = count;
        ptr_next   = ptr;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        valid_next = 1'b0;
        instr_next = {2'b00, NOP_OPCODE};
        data_next  = 8'h00;
        case (state)
            IDLE: begin
                if (clear) begin
                    count_next = '0;
                end else begin
                    if (load_fire) count_next = count + CW'(1);
                    if (start) begin
                        if (eff_count != '0) begin
                            state_next = RUN;
                            busy_next  = 1'b1;
                            valid_next = 1'b1;
                            instr_next = first_instr;
                            data_next  = first_data;
                            ptr_next   = (eff_count == CW'(1)) ? '0 : PW'(1);
                        end else begin
                            done_next = 1'b1;
                        end
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end else if (ptr == '0 && !loop_en) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    busy_next  = 1'b1;
                    valid_next = 1'b1;
                    instr_next = instr_mem[ptr];
                    data_next  = data_mem[ptr];
                    ptr_next   = (ptr_inc == count) ? '0 : ptr_inc[PW-1:0];
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            count            <= '0;
            ptr              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            alu_valid        <= 1'b0;
            alu_accum_source <= 1'b0;
            alu_value_source <= 1'b0;
            alu_opcode       <= NOP_OPCODE;
            alu_data         <= 8'h00;
        end else begin
            state            <= state_next;
            count            <= count_next;
            ptr              <= ptr_next;
            busy             <= busy_next;
            done             <= done_next;
            alu_valid        <= valid_next;
            alu_accum_source <= instr_next[5];
            alu_value_source <= instr_next[4];
            alu_opcode       <= instr_next[3:0];
            alu_data         <= data_next;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed, table-driven bench for alu_op_sequencer with hand-written
// sequences for the full-program, async-reset and mid-run corner cases.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_valid, load_ready;
    logic [5:0] load_instr;
    logic [7:0] load_data;
    logic       clear, start, loop_en, stop;
    logic       busy, done, alu_valid;
    logic [3:0] count;
    logic       alu_accum_source, alu_value_source;
    logic [3:0] alu_opcode;
    logic [7:0] alu_data;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic       lv;
        logic [5:0] instr;
        logic [7:0] data;
        logic       clr, st, lp, sp;
        logic       e_ready, e_busy, e_done, e_valid;
        logic [5:0] e_instr;
        logic [7:0] e_data;
        logic [3:0] e_count;
    } vec_t;

    vec_t vecs[$];

    alu_op_sequencer #(.DEPTH(8), .NOP_OPCODE(4'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_instr(load_instr), .load_data(load_data),
        .clear(clear), .start(start), .loop_en(loop_en), .stop(stop),
        .busy(busy), .done(done), .count(count),
        .alu_accum_source(alu_accum_source), .alu_value_source(alu_value_source),
        .alu_opcode(alu_opcode), .alu_data(alu_data), .alu_valid(alu_valid)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic lv, logic [5:0] instr, logic [7:0] data,
                                logic clr, logic st, logic lp, logic sp,
                                logic e_ready, logic e_busy, logic e_done, logic e_valid,
                                logic [5:0] e_instr, logic [7:0] e_data, logic [3:0] e_count);
        vec_t v;
        v.lv = lv; v.instr = instr; v.data = data;
        v.clr = clr; v.st = st; v.lp = lp; v.sp = sp;
        v.e_ready = e_ready; v.e_busy = e_busy; v.e_done = e_done; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_data = e_data; v.e_count = e_count;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic lv, input logic [5:0] instr, input logic [7:0] data,
                         input logic clr, input logic st, input logic lp, input logic sp);
        @(negedge clk);
        load_valid = lv; load_instr = instr; load_data = data;
        clear = clr; start = st; loop_en = lp; stop = sp;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRegs(input string tag, input logic e_busy, input logic e_done,
                             input logic e_valid, input logic [5:0] e_instr,
                             input logic [7:0] e_data, input logic [3:0] e_count);
        checkOutput({tag, ".busy"},  int'(busy), int'(e_busy));
        checkOutput({tag, ".done"},  int'(done), int'(e_done));
        checkOutput({tag, ".valid"}, int'(alu_valid), int'(e_valid));
        checkOutput({tag, ".instr"}, int'({alu_accum_source, alu_value_source, alu_opcode}), int'(e_instr));
        checkOutput({tag, ".data"},  int'(alu_data), int'(e_data));
        checkOutput({tag, ".count"}, int'(count), int'(e_count));
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        drive(v.lv, v.instr, v.data, v.clr, v.st, v.lp, v.sp);
        #1;
        checkOutput({tag, ".load_ready"}, int'(load_ready), int'(v.e_ready));
        step();
        checkRegs(tag, v.e_busy, v.e_done, v.e_valid, v.e_instr, v.e_data, v.e_count);
    endtask

    logic [5:0] model_instr [8];
    logic [7:0] model_data  [8];

    initial begin
        rst_n = 1'b0;
        load_valid = 0; load_instr = 0; load_data = 0;
        clear = 0; start = 0; loop_en = 0; stop = 0;

        // Basic 3-entry program, start together with the third load
        vecs.push_back(mk(1,'h21,'h05,0,0,0,0, 1,0,0,0,'h00,'h00,1));
        vecs.push_back(mk(1,'h02,'h10,0,0,0,0, 1,0,0,0,'h00,'h00,2));
        vecs.push_back(mk(1,'h13,'hFF,0,1,0,0, 1,1,0,1,'h21,'h05,3));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,1,0,1,'h02,'h10,3));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,1,0,1,'h13,'hFF,3));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,'h00,'h00,3));
        vecs.push_back(mk(0,0,0,0,0,0,0, 1,0,0,0,'h00,'h00,3));
        // Looping replay, then drop loop_en during the last entry
        vecs.push_back(mk(0,0,0,0,1,1,0, 1,1,0,1,'h21,'h05,3));
        vecs.push_back(mk(0,0,0,0,0,1,0, 0,1,0,1,'h02,'h10,3));
        vecs.push_back(mk(0,0,0,0,0,1,0, 0,1,0,1,'h13,'hFF,3));
        vecs.push_back(mk(0,0,0,0,0,1,0, 0,1,0,1,'h21,'h05,3));
        vecs.push_back(mk(0,0,0,0,0,1,0, 0,1,0,1,'h02,'h10,3));
        vecs.push_back(mk(0,0,0,0,0,1,0, 0,1,0,1,'h13,'hFF,3));
        vecs.push_back(mk(0,0,0,0,0,1,0, 0,1,0,1,'h21,'h05,3));
        vecs.push_back(mk(0,0,0,0,0,1,0, 0,1,0,1,'h02,'h10,3));
        vecs.push_back(mk(0,0,0,0,0,1,0, 0,1,0,1,'h13,'hFF,3));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,'h00,'h00,3));
        vecs.push_back(mk(0,0,0,0,0,0,0, 1,0,0,0,'h00,'h00,3));
        // Stop at entry 1; load/clear ignored while running
        vecs.push_back(mk(0,0,0,0,1,0,0, 1,1,0,1,'h21,'h05,3));
        vecs.push_back(mk(1,'h3F,'hAA,1,0,0,0, 0,1,0,1,'h02,'h10,3));
        vecs.push_back(mk(0,0,0,0,0,0,1, 0,0,0,0,'h00,'h00,3));
        vecs.push_back(mk(0,0,0,0,0,0,0, 1,0,0,0,'h00,'h00,3));
        // Stop coinciding with the final entry suppresses done
        vecs.push_back(mk(0,0,0,0,1,0,0, 1,1,0,1,'h21,'h05,3));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,1,0,1,'h02,'h10,3));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,1,0,1,'h13,'hFF,3));
        vecs.push_back(mk(0,0,0,0,0,0,1, 0,0,0,0,'h00,'h00,3));
        // Clear beats load, empty start, start with first load
        vecs.push_back(mk(1,'h3F,'hAA,1,0,0,0, 0,0,0,0,'h00,'h00,0));
        vecs.push_back(mk(0,0,0,0,1,0,0, 1,0,1,0,'h00,'h00,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 1,0,0,0,'h00,'h00,0));
        vecs.push_back(mk(1,'h2A,'h77,0,1,0,0, 1,1,0,1,'h2A,'h77,1));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,'h00,'h00,1));
        vecs.push_back(mk(0,0,0,0,0,0,0, 1,0,0,0,'h00,'h00,1));

        #3;
        checkRegs("reset", 0, 0, 0, 6'h00, 8'h00, 4'd0);
        #9 rst_n = 1'b1;

        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // Fill to DEPTH, offer a ninth entry, replay once
        drive(0,0,0,1,0,0,0);
        step();
        checkOutput("full.cleared", int'(count), 0);
        for (int i = 0; i < 8; i++) begin
            model_instr[i] = 6'(i * 5 + 1);
            model_data[i]  = 8'(i * 17 + 3);
            drive(1, model_instr[i], model_data[i], 0, 0, 0, 0);
            #1;
            checkOutput($sformatf("full.ready%0d", i), int'(load_ready), 1);
            step();
            checkOutput($sformatf("full.count%0d", i), int'(count), i + 1);
        end
        drive(1, 6'h3F, 8'hEE, 0, 0, 0, 0);
        #1;
        checkOutput("full.ready_when_full", int'(load_ready), 0);
        step();
        checkOutput("full.count_no_wrap", int'(count), 8);
        drive(0,0,0,0,1,0,0);
        step();
        for (int i = 0; i < 8; i++) begin
            checkRegs($sformatf("full.entry%0d", i), 1, 0, 1, model_instr[i], model_data[i], 4'd8);
            drive(0,0,0,0,0,0,0);
            step();
        end
        checkRegs("full.end", 0, 1, 0, 6'h00, 8'h00, 4'd8);

        // Asynchronous reset between edges while running
        drive(0,0,0,0,1,1,0);
        step();
        checkOutput("arst.pre_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        checkRegs("arst", 0, 0, 0, 6'h00, 8'h00, 4'd0);
        drive(0,0,0,0,0,0,0);
        rst_n = 1'b1;
        step();
        checkRegs("arst.after", 0, 0, 0, 6'h00, 8'h00, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
